// File: rtl/fir_stream_pkg.sv
// Shared widths and requantisation helpers for the FIR output stream.
// Used by the result sink RTL and by the filter's reference model.
package fir_stream_pkg;

    localparam int IN_W_DEF  = 32;
    localparam int OUT_W_DEF = 16;

    // Half-LSB bias of the post-shift grid; zero shift means no rounding at all.
    function automatic int round_bias(input int shift);
        return (shift > 0) ? (1 << (shift - 1)) : 0;
    endfunction

    // Wide reference form: round-half-up, shift, unsigned saturate to out_w bits.
    function automatic logic [63:0] requant(input logic [63:0] din, input int shift, input int out_w);
        logic [63:0] r;
        logic [63:0] max_v;
        r     = (din + 64'(round_bias(shift))) >> shift;
        max_v = (64'd1 << out_w) - 64'd1;
        return (r > max_v) ? max_v : r;
    endfunction

endpackage

// File: rtl/fir_result_sink_if.sv
// Filter-to-sink stream (valid only) plus the sink's valid/ready read port.
interface fir_result_sink_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (output in_valid, in_data, out_ready, input out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output out_valid, out_data);
endinterface

// File: rtl/fir_sync_fifo.sv
// Purpose: DEPTH x W synchronous FIFO, first-word-fall-through, with occupancy count.
// Latency: a push is visible at pop_dat the cycle after it is written.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module fir_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign rd_en   = pop && !empty;
    // A pop frees the head slot this cycle, so a full FIFO can still take the push.
    assign wr_en   = push && (!full || rd_en);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fir_result_sink.sv
// Purpose: requantise FIR results to OUT_W bits and buffer them for a valid/ready reader.
// Latency: 2 cycles from in_valid to out_valid into an empty FIFO; 1 sample/cycle sustained.
// Backpressure: none upstream; samples arriving at a full FIFO without a pop are dropped and counted.
module fir_result_sink
    import fir_stream_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = 4,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fir_result_sink_if.slave         bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count,
    input  logic                     clr_ovf
);
    localparam logic [IN_W:0] RND = (IN_W+1)'(round_bias(SHIFT));
    localparam logic [IN_W:0] SAT = (IN_W+1)'({OUT_W{1'b1}});

    logic [IN_W:0]    r_sum;
    logic             q_valid;
    logic [OUT_W-1:0] q_data;
    logic [OUT_W-1:0] fifo_dat;
    logic             full;
    logic             empty;
    logic             pop;
    logic             drop;

    // One spare bit keeps the rounding carry of an all-ones input from wrapping.
    assign r_sum = ({1'b0, bus.in_data} + RND) >> SHIFT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else begin
            q_valid <= bus.in_valid;
            q_data  <= (r_sum > SAT) ? '1 : r_sum[OUT_W-1:0];
        end
    end

    fir_sync_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (q_valid),
        .push_dat (q_data),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    assign pop           = !empty && bus.out_ready;
    assign drop          = q_valid && full && !pop;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : fifo_dat;

    // A drop in the clearing cycle survives the clear as the first counted drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clr_ovf) begin
            overflow   <= drop;
            drop_count <= drop ? CNT_W'(1) : '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= (drop_count == '1) ? drop_count : drop_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fir_result_sink.sv
// Directed and random stimulus for fir_result_sink against a queue-based reference model.
module tb_fir_result_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_ovf;
    logic [3:0]  level, level2;
    logic        overflow, overflow2;
    logic [15:0] drop_count;
    logic [1:0]  drop_count2;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model state
    int q[$];
    bit pend_v;
    int pend_d;
    bit m_ovf;
    int m_cnt;
    int m_cnt2;

    fir_result_sink_if #(.IN_W(32), .OUT_W(16)) bus ();
    fir_result_sink_if #(.IN_W(32), .OUT_W(16)) bus2 ();

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_data   = bus.in_data;
    assign bus2.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    fir_result_sink #(.IN_W(32), .OUT_W(16), .SHIFT(4), .DEPTH(8), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clr_ovf    (clr_ovf)
    );

    fir_result_sink #(.IN_W(32), .OUT_W(16), .SHIFT(4), .DEPTH(8), .CNT_W(2)) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus2.slave),
        .level      (level2),
        .overflow   (overflow2),
        .drop_count (drop_count2),
        .clr_ovf    (clr_ovf)
    );

    function automatic int ref_q(input logic [31:0] x);
        longint unsigned v;
        v = (longint'(x) + 64'd8) / 64'd16;
        return (v > 65535) ? 65535 : int'(v);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend_v = 0;
        pend_d = 0;
        m_ovf  = 0;
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    task automatic check_all(input string tag);
        int hd;
        hd = (q.size() > 0) ? q[0] : 0;
        chk({tag, ".out_valid"}, bus.out_valid, (q.size() > 0));
        chk({tag, ".out_data"},  bus.out_data, hd);
        chk({tag, ".level"},     level, q.size());
        chk({tag, ".overflow"},  overflow, m_ovf);
        chk({tag, ".drop_count"}, drop_count, m_cnt);
        chk({tag, ".out_data2"}, bus2.out_data, hd);
        chk({tag, ".level2"},    level2, q.size());
        chk({tag, ".drop_count2"}, drop_count2, m_cnt2);
    endtask

    // Advance one clock, apply the reference rules for that edge, compare everything.
    task automatic step(input string tag);
        bit pop, drop;
        @(posedge clk);
        #1;
        pop  = (q.size() > 0) && bus.out_ready;
        drop = 0;
        if (pop) void'(q.pop_front());
        if (pend_v) begin
            if (q.size() < 8) q.push_back(pend_d);
            else drop = 1;
        end
        if (clr_ovf) begin
            m_ovf  = drop;
            m_cnt  = drop ? 1 : 0;
            m_cnt2 = drop ? 1 : 0;
        end else if (drop) begin
            m_ovf = 1;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        pend_v = bus.in_valid;
        pend_d = ref_q(bus.in_data);
        check_all(tag);
    endtask

    logic [31:0] t3_in  [6] = '{32'd24, 32'd23, 32'd8, 32'd7, 32'h0010_0000, 32'hFFFF_FFFF};
    logic [15:0] t3_exp [6] = '{16'd2, 16'd1, 16'd1, 16'd0, 16'hFFFF, 16'hFFFF};

    initial begin
        int nxt;
        rst_n         = 1'b0;
        clr_ovf       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();

        // 1: reset values, then an asynchronous reset in the middle of a burst
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_all("rst");
        step("rst_idle");
        for (int k = 1; k <= 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(k * 100);
            step("burst");
        end
        chk("burst_level_nonzero", (level != 0), 1'b1);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("async_rst");
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("post_rst");

        // 2: single sample, two-cycle latency, then one pop
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd280;
        step("single_c1");
        chk("lat_not_yet", bus.out_valid, 1'b0);
        bus.in_valid = 1'b0;
        step("single_c2");
        chk("single_valid", bus.out_valid, 1'b1);
        chk("single_data", bus.out_data, 16'd18);
        chk("single_level", level, 4'd1);
        bus.out_ready = 1'b1;
        step("single_pop");
        chk("pop_data_zero", bus.out_data, 16'd0);
        bus.out_ready = 1'b0;

        // 3: rounding and saturation
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = t3_in[i];
            step("rq_in");
            bus.in_valid = 1'b0;
            step("rq_wait");
            chk("requant", bus.out_data, t3_exp[i]);
            bus.out_ready = 1'b1;
            step("rq_pop");
            bus.out_ready = 1'b0;
        end

        // 4: overfill by two, ordered drain, clear
        for (int k = 1; k <= 10; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(16 * k);
            step("ovf_fill");
        end
        bus.in_valid = 1'b0;
        step("ovf_flush");
        chk("ovf_level", level, 4'd8);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_count", drop_count, 16'd2);
        for (int k = 1; k <= 8; k++) begin
            chk("ovf_order", bus.out_data, 16'(k));
            bus.out_ready = 1'b1;
            step("ovf_drain");
        end
        bus.out_ready = 1'b0;
        clr_ovf = 1'b1;
        step("ovf_clr");
        clr_ovf = 1'b0;
        chk("clr_flag", overflow, 1'b0);
        chk("clr_count", drop_count, 16'd0);

        // 5: full FIFO with simultaneous push and pop
        for (int k = 1; k <= 9; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(16 * k);
            step("full_fill");
        end
        chk("full_level", level, 4'd8);
        nxt = 1;
        bus.out_ready = 1'b1;
        for (int k = 10; k <= 13; k++) begin
            chk("full_order", bus.out_data, 16'(nxt));
            bus.in_data = 32'(16 * k);
            step("full_stream");
            nxt++;
            chk("full_hold", level, 4'd8);
            chk("full_nodrop", drop_count, 16'd0);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && nxt <= 13; i++) begin
            chk("full_order", bus.out_data, 16'(nxt));
            step("full_drain");
            nxt++;
        end
        chk("full_drained", nxt, 14);
        chk("full_empty", level, 4'd0);
        bus.out_ready = 1'b0;

        // 6: counter saturation on the narrow instance, clear colliding with a drop
        for (int k = 1; k <= 13; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(16 * k);
            step("sat_fill");
        end
        bus.in_valid = 1'b0;
        step("sat_flush");
        chk("sat_wide", drop_count, 16'd5);
        chk("sat_narrow", drop_count2, 2'd3);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd999;
        step("clr_drop_pre");
        bus.in_valid = 1'b0;
        clr_ovf = 1'b1;
        step("clr_drop");
        clr_ovf = 1'b0;
        chk("clr_drop_flag", overflow, 1'b1);
        chk("clr_drop_cnt", drop_count, 16'd1);
        chk("clr_drop_cnt2", drop_count2, 2'd1);
        bus.out_ready = 1'b1;
        repeat (9) step("sat_drain");

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       bus.in_data = $urandom_range(0, 40);
                1:       bus.in_data = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                2:       bus.in_data = $urandom_range(0, 1_048_600);
                default: bus.in_data = $urandom;
            endcase
            bus.out_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            clr_ovf       = ($urandom_range(0, 31) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
